// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//
// Shared definitions for the Pong ball path:
//   - tile geometry (TILE_SHIFT: 16-pixel tiles) and default playfield size
//   - ball coordinate width
//   - ball controller state encoding (IDLE, RUN)
//   - direction encoding: 0 = right/down, 1 = left/up
//   - step_coord(): move a tile coordinate one step up or down
// -----------------------------------------------------------------------------
package pong_pkg;

   // Pixel counters are divided by 16 to get tile coordinates.
   localparam int TILE_SHIFT      = 4;

   // Default playfield in tiles (640x480 / 16).
   localparam int DEF_GAME_WIDTH  = 40;
   localparam int DEF_GAME_HEIGHT = 30;

   // Ball tile coordinates are 6-bit unsigned.
   localparam int COORD_W         = 6;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ball_state_t;

   // Direction bits: 0 moves toward larger coordinates, 1 toward smaller.
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // One tile step. Callers guarantee the result never wraps because the
   // edges/walls are handled before a step could leave the playfield.
   function automatic logic [COORD_W-1:0] step_coord(
      input logic [COORD_W-1:0] coord,
      input logic               decrement
   );
      return decrement ? (coord - COORD_W'(1)) : (coord + COORD_W'(1));
   endfunction

endpackage

// File: rtl/pong_step_timer.sv
// -----------------------------------------------------------------------------
// pong_step_timer
//
// Free-running divider that paces the ball. Counts 0..BALL_SPEED-1 while
// enabled and wraps; o_Step is high for the single cycle in which the count
// sits at its terminal value (and the timer is enabled).
//
// Ports:
//   i_Clk     pixel clock
//   i_Rst_L   asynchronous active-low reset (count -> 0)
//   i_Clear   synchronous clear; count is 0 in the following cycle
//   i_Enable  advance the count
//   o_Step    one-cycle step strobe on the terminal-count cycle
// -----------------------------------------------------------------------------
module pong_step_timer #(
   parameter int BALL_SPEED = 1250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Step
);

   localparam int              CNT_W    = (BALL_SPEED > 1) ? $clog2(BALL_SPEED) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BALL_SPEED - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             at_terminal;

   assign at_terminal = (count_reg == TERMINAL);

   // The strobe deliberately ignores i_Clear: the clear is derived from the
   // controller's next state, which itself depends on this strobe.
   assign o_Step = i_Enable && at_terminal;

   always_comb begin
      count_next = count_reg;
      if (i_Clear) begin
         count_next = '0;
      end else if (i_Enable) begin
         count_next = at_terminal ? '0 : (count_reg + CNT_W'(1));
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/pong_ball_ctrl.sv
// -----------------------------------------------------------------------------
// pong_ball_ctrl
//
// Ball controller for the Pong display pipeline. Holds the ball's tile
// position and direction, steps it every BALL_SPEED cycles while the game is
// active, bounces it off the top/bottom walls and reports misses at the
// left/right edges. Also produces the ball draw flag for the current pixel,
// re-aligned with the incoming syncs (1 cycle latency on all three).
//
// Ports:
//   i_Clk          pixel clock
//   i_Rst_L        asynchronous active-low reset
//   i_HSync        horizontal sync, aligned with the counters
//   i_VSync        vertical sync, aligned with the counters
//   i_Col_Count    current pixel column (10 bits)
//   i_Row_Count    current pixel row (10 bits)
//   i_Game_Active  level, 1 = ball in play
//   i_Reflect_X    one-cycle pulse from paddle logic, flips horizontal dir
//   o_HSync        i_HSync delayed one cycle
//   o_VSync        i_VSync delayed one cycle
//   o_Draw_Ball    current (delayed) pixel lies inside the ball tile
//   o_Ball_X       ball tile column
//   o_Ball_Y       ball tile row
//   o_Miss_L       one-cycle pulse: ball reached column 0
//   o_Miss_R       one-cycle pulse: ball reached column GAME_WIDTH-1
// -----------------------------------------------------------------------------
module pong_ball_ctrl
   import pong_pkg::*;
#(
   parameter int GAME_WIDTH  = DEF_GAME_WIDTH,
   parameter int GAME_HEIGHT = DEF_GAME_HEIGHT,
   parameter int BALL_SPEED  = 1250000
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_HSync,
   input  logic                i_VSync,
   input  logic [9:0]          i_Col_Count,
   input  logic [9:0]          i_Row_Count,
   input  logic                i_Game_Active,
   input  logic                i_Reflect_X,
   output logic                o_HSync,
   output logic                o_VSync,
   output logic                o_Draw_Ball,
   output logic [COORD_W-1:0]  o_Ball_X,
   output logic [COORD_W-1:0]  o_Ball_Y,
   output logic                o_Miss_L,
   output logic                o_Miss_R
);

   localparam logic [COORD_W-1:0] X_CENTRE = COORD_W'(GAME_WIDTH / 2);
   localparam logic [COORD_W-1:0] Y_CENTRE = COORD_W'(GAME_HEIGHT / 2);
   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GAME_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GAME_HEIGHT - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   ball_state_t         state_reg,  state_next;
   logic [COORD_W-1:0]  ball_x_reg, ball_x_next;
   logic [COORD_W-1:0]  ball_y_reg, ball_y_next;
   logic                x_dir_reg,  x_dir_next;
   logic                y_dir_reg,  y_dir_next;
   logic                miss_l_reg, miss_l_next;
   logic                miss_r_reg, miss_r_next;

   logic                hsync_reg;
   logic                vsync_reg;
   logic                draw_reg;
   logic                draw_next;

   // ---------------------------------------------------------------------
   // Step timer: runs only in RUN, cleared whenever the FSM is (or is about
   // to be) in IDLE so the first step lands BALL_SPEED cycles after serve.
   // ---------------------------------------------------------------------
   logic step_strobe;
   logic timer_clear;
   logic timer_enable;

   assign timer_enable = (state_reg == RUN);
   assign timer_clear  = (state_next == IDLE);

   pong_step_timer #(
      .BALL_SPEED (BALL_SPEED)
   ) u_step_timer (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Clear  (timer_clear),
      .i_Enable (timer_enable),
      .o_Step   (step_strobe)
   );

   // ---------------------------------------------------------------------
   // Candidate step
   // ---------------------------------------------------------------------
   logic                x_dir_eff;
   logic [COORD_W-1:0]  stepped_x;
   logic                hit_left;
   logic                hit_right;
   logic                at_floor;
   logic                at_ceiling;
   logic                bounced_y_dir;
   logic [COORD_W-1:0]  stepped_y;

   // A reflect pulse in the step cycle already steers that step.
   assign x_dir_eff = x_dir_reg ^ ((state_reg == RUN) && i_Reflect_X);
   assign stepped_x = step_coord(ball_x_reg, x_dir_eff == DIR_LEFT);
   assign hit_left  = (stepped_x == '0);
   assign hit_right = (stepped_x == X_MAX);

   // Wall bounce: flip y direction first, then step with the new direction,
   // so the ball moves away from the wall in the same step.
   assign at_floor      = (y_dir_reg == DIR_DOWN) && (ball_y_reg == Y_MAX);
   assign at_ceiling    = (y_dir_reg == DIR_UP)   && (ball_y_reg == '0);
   assign bounced_y_dir = (at_floor || at_ceiling) ? ~y_dir_reg : y_dir_reg;
   assign stepped_y     = step_coord(ball_y_reg, bounced_y_dir == DIR_UP);

   // ---------------------------------------------------------------------
   // FSM next-state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      ball_x_next = ball_x_reg;
      ball_y_next = ball_y_reg;
      x_dir_next  = x_dir_reg;
      y_dir_next  = y_dir_reg;
      miss_l_next = 1'b0;
      miss_r_next = 1'b0;

      case (state_reg)
         IDLE: begin
            ball_x_next = X_CENTRE;
            ball_y_next = Y_CENTRE;
            if (i_Game_Active) begin
               state_next = RUN;
            end
         end

         RUN: begin
            x_dir_next = x_dir_eff;

            if (step_strobe) begin
               if (hit_left || hit_right) begin
                  // Miss: recentre and serve toward the player who scored.
                  miss_l_next = hit_left;
                  miss_r_next = hit_right;
                  state_next  = IDLE;
                  ball_x_next = X_CENTRE;
                  ball_y_next = Y_CENTRE;
                  x_dir_next  = ~x_dir_eff;
               end else begin
                  ball_x_next = stepped_x;
                  ball_y_next = stepped_y;
                  y_dir_next  = bounced_y_dir;
               end
            end

            // Game stopped: park at centre. Any miss flagged above still
            // goes out, and IDLE is entered only once.
            if (!i_Game_Active) begin
               state_next  = IDLE;
               ball_x_next = X_CENTRE;
               ball_y_next = Y_CENTRE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_reg  <= IDLE;
         ball_x_reg <= X_CENTRE;
         ball_y_reg <= Y_CENTRE;
         x_dir_reg  <= DIR_RIGHT;
         y_dir_reg  <= DIR_DOWN;
         miss_l_reg <= 1'b0;
         miss_r_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ball_x_reg <= ball_x_next;
         ball_y_reg <= ball_y_next;
         x_dir_reg  <= x_dir_next;
         y_dir_reg  <= y_dir_next;
         miss_l_reg <= miss_l_next;
         miss_r_reg <= miss_r_next;
      end
   end

   // ---------------------------------------------------------------------
   // Draw / sync pipeline. The tile compare uses the position held before
   // the edge, so the flag belongs to the pixel whose syncs are delayed
   // alongside it.
   // ---------------------------------------------------------------------
   logic unused_low_bits;
   assign unused_low_bits = ^{i_Col_Count[TILE_SHIFT-1:0], i_Row_Count[TILE_SHIFT-1:0]};

   assign draw_next = (i_Col_Count[9:TILE_SHIFT] == ball_x_reg) &&
                      (i_Row_Count[9:TILE_SHIFT] == ball_y_reg);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         hsync_reg <= 1'b0;
         vsync_reg <= 1'b0;
         draw_reg  <= 1'b0;
      end else begin
         hsync_reg <= i_HSync;
         vsync_reg <= i_VSync;
         draw_reg  <= draw_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign o_HSync     = hsync_reg;
   assign o_VSync     = vsync_reg;
   assign o_Draw_Ball = draw_reg;
   assign o_Ball_X    = ball_x_reg;
   assign o_Ball_Y    = ball_y_reg;
   assign o_Miss_L    = miss_l_reg;
   assign o_Miss_R    = miss_r_reg;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_ball_ctrl
//
// Scoreboard bench for pong_ball_ctrl with BALL_SPEED=4. Stimulus pushes the
// hand-computed ball events (position change or miss pulse, with the cycle
// they must appear in) and per-cycle draw/sync expectations into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents
// an event.
// -----------------------------------------------------------------------------
module tb_pong_ball_ctrl;

   localparam int SPD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hs, vs, ga, refl;
   logic [9:0] col, row;
   logic       o_hs, o_vs, o_draw, o_ml, o_mr;
   logic [5:0] o_x, o_y;

   pong_ball_ctrl #(
      .GAME_WIDTH  (40),
      .GAME_HEIGHT (30),
      .BALL_SPEED  (SPD)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_n),
      .i_HSync       (hs),
      .i_VSync       (vs),
      .i_Col_Count   (col),
      .i_Row_Count   (row),
      .i_Game_Active (ga),
      .i_Reflect_X   (refl),
      .o_HSync       (o_hs),
      .o_VSync       (o_vs),
      .o_Draw_Ball   (o_draw),
      .o_Ball_X      (o_x),
      .o_Ball_Y      (o_y),
      .o_Miss_L      (o_ml),
      .o_Miss_R      (o_mr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int x; int y; int ml; int mr; } ev_t;
   typedef struct { int cyc; int draw; int hs; int vs; }      dr_t;
   ev_t ev_q[$];
   dr_t dr_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_ev(input int c, input int x, input int y, input int ml, input int mr);
      ev_t e;
      e.cyc = c; e.x = x; e.y = y; e.ml = ml; e.mr = mr;
      ev_q.push_back(e);
   endtask

   // Hand-computed trajectories (one entry per step; last entry is the miss).
   // Run 1: from centre right/down, reflect at X=25, floor bounce, miss left.
   int r1_x[30] = '{21,22,23,24,25,24,23,22,21,20,19,18,17,16,15,
                    14,13,12,11,10, 9, 8, 7, 6, 5, 4, 3, 2, 1,20};
   int r1_y[30] = '{16,17,18,19,20,21,22,23,24,25,26,27,28,29,28,
                    27,26,25,24,23,22,21,20,19,18,17,16,15,14,15};
   // Run 2: serve right/up, ceiling bounce, miss right.
   int r2_x[19] = '{21,22,23,24,25,26,27,28,29,30,31,32,33,34,35,36,37,38,20};
   int r2_y[19] = '{14,13,12,11,10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3,15};

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin
      int  px, py;
      bit  evt;
      ev_t e;
      dr_t d;
      px = -1;
      py = -1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            px = int'(o_x);
            py = int'(o_y);
         end else begin
            evt = (int'(o_x) != px) || (int'(o_y) != py) || o_ml || o_mr;
            if (evt) begin
               if (ev_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_event: got x=%0d y=%0d ml=%0d mr=%0d, expected no event (cycle %0d)",
                           o_x, o_y, o_ml, o_mr, cyc);
               end else begin
                  e = ev_q.pop_front();
                  check("event_cycle", cyc, e.cyc);
                  check("event_x", int'(o_x), e.x);
                  check("event_y", int'(o_y), e.y);
                  check("event_miss_l", int'(o_ml), e.ml);
                  check("event_miss_r", int'(o_mr), e.mr);
               end
            end else if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
               e = ev_q.pop_front();
               check("missed_event_cycle", cyc, e.cyc);
            end
            px = int'(o_x);
            py = int'(o_y);

            while (dr_q.size() > 0 && dr_q[0].cyc < cyc) begin
               d = dr_q.pop_front();
               check("draw_sample_lost", cyc, d.cyc);
            end
            if (dr_q.size() > 0 && dr_q[0].cyc == cyc) begin
               d = dr_q.pop_front();
               check("draw_ball", int'(o_draw), d.draw);
               check("draw_hsync", int'(o_hs), d.hs);
               check("draw_vsync", int'(o_vs), d.vs);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic check_reset_outputs(input string tag);
      check({tag, "_ball_x"}, int'(o_x), 20);
      check({tag, "_ball_y"}, int'(o_y), 15);
      check({tag, "_miss_l"}, int'(o_ml), 0);
      check({tag, "_miss_r"}, int'(o_mr), 0);
      check({tag, "_draw"},   int'(o_draw), 0);
      check({tag, "_hsync"},  int'(o_hs), 0);
      check({tag, "_vsync"},  int'(o_vs), 0);
   endtask

   initial begin
      int cr;
      int ed, ehs, evs;
      int rows[5] = '{239, 240, 247, 255, 256};

      rst_n = 1'b0;
      hs = 1'b0; vs = 1'b0; ga = 1'b0; refl = 1'b0;
      col = '0; row = '0;

      repeat (3) tick();
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      repeat (100) tick();
      check_reset_outputs("idle_100");
      $display("[TB] reset/idle: ball=(%0d,%0d)", o_x, o_y);

      // Run 1: reflect on step 6, floor bounce, miss left after 30 steps.
      ga = 1'b1;
      cr = cyc + 1;
      for (int k = 0; k < 30; k++)
         push_ev(cr + SPD * (k + 1), r1_x[k], r1_y[k], (k == 29) ? 1 : 0, 0);
      wait_until(cr + 6 * SPD - 1);
      refl = 1'b1;
      tick();
      refl = 1'b0;
      wait_until(cr + 30 * SPD);
      $display("[TB] run1 (reflect, floor, miss L) done at cycle %0d", cyc);

      // Run 2: auto re-serve right/up, ceiling bounce, miss right with the
      // game dropping in the same cycle as the missing step.
      cr = cr + 30 * SPD + 1;
      for (int k = 0; k < 19; k++)
         push_ev(cr + SPD * (k + 1), r2_x[k], r2_y[k], 0, (k == 18) ? 1 : 0);
      wait_until(cr + 19 * SPD - 1);
      ga = 1'b0;
      tick();
      repeat (10) tick();
      $display("[TB] run2 (ceiling, miss R + game off) done at cycle %0d", cyc);

      // Reflect in IDLE must be ignored: next serve still goes left/down.
      refl = 1'b1;
      tick();
      refl = 1'b0;
      repeat (3) tick();
      ga = 1'b1;
      cr = cyc + 1;
      push_ev(cr + 1 * SPD, 19, 16, 0, 0);
      push_ev(cr + 2 * SPD, 18, 17, 0, 0);
      push_ev(cr + 3 * SPD, 17, 18, 0, 0);
      push_ev(cr + 3 * SPD + 2, 20, 15, 0, 0);
      wait_until(cr + 3 * SPD + 1);
      ga = 1'b0;
      repeat (5) tick();
      $display("[TB] run3 (idle reflect ignored, game off recentre) done at cycle %0d", cyc);

      // Draw alignment around tile (20,15) = cols 320..335, rows 240..255.
      foreach (rows[r]) begin
         for (int c = 316; c < 340; c++) begin
            col = 10'(c);
            row = 10'(rows[r]);
            ehs = ((c % 3) == 0) ? 1 : 0;
            evs = (((c + rows[r]) % 5) == 0) ? 1 : 0;
            hs  = ehs[0];
            vs  = evs[0];
            ed  = (c >= 320 && c <= 335 && rows[r] >= 240 && rows[r] <= 255) ? 1 : 0;
            dr_q.push_back('{cyc: cyc + 1, draw: ed, hs: ehs, vs: evs});
            tick();
         end
         $display("[TB] draw row %0d swept", rows[r]);
      end
      hs = 1'b0; vs = 1'b0; col = '0; row = '0;
      repeat (3) tick();

      // Reset in the middle of RUN, with draw and syncs high beforehand.
      col = 10'(18 * 16);
      row = 10'(17 * 16);
      hs = 1'b1; vs = 1'b1;
      ga = 1'b1;
      cr = cyc + 1;
      push_ev(cr + 1 * SPD, 19, 16, 0, 0);
      push_ev(cr + 2 * SPD, 18, 17, 0, 0);
      wait_until(cr + 2 * SPD + 2);
      check("prereset_draw", int'(o_draw), 1);
      check("prereset_hsync", int'(o_hs), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      tick();
      tick();
      check_reset_outputs("held_reset");
      ga = 1'b0; hs = 1'b0; vs = 1'b0; col = '0; row = '0;
      rst_n = 1'b1;
      repeat (4) tick();
      check_reset_outputs("after_reset");
      $display("[TB] mid-run reset checked at cycle %0d", cyc);

      // After reset the serve must again be right/down with a fresh counter.
      ga = 1'b1;
      cr = cyc + 1;
      push_ev(cr + 1 * SPD, 21, 16, 0, 0);
      push_ev(cr + 2 * SPD, 22, 17, 0, 0);
      push_ev(cr + 2 * SPD + 2, 20, 15, 0, 0);
      wait_until(cr + 2 * SPD + 1);
      ga = 1'b0;
      repeat (6) tick();
      $display("[TB] post-reset serve checked at cycle %0d", cyc);

      check("events_left_over", ev_q.size(), 0);
      check("draw_left_over", dr_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_ball_ctrl.md
# pong_ball_ctrl

Ball controller for the Pong display pipeline. Sits directly downstream of the sync-to-count stage: consumes its aligned HSync/VSync and Row/Col counters, maintains the ball's tile position and direction, advances it at a fixed rate, bounces it off the top and bottom walls, and reports misses at the left and right edges. Produces a one-cycle-delayed draw flag with re-aligned syncs for the pixel-mux stage.

## Interface
- GAME_WIDTH, 40: playfield width in tiles (16-pixel tiles).
- GAME_HEIGHT, 30: playfield height in tiles.
- BALL_SPEED, 1250000: clock cycles per ball step.
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_HSync  in  1  horizontal sync, aligned with counts.
- i_VSync  in  1  vertical sync, aligned with counts.
- i_Col_Count  in  10  current column.
- i_Row_Count  in  10  current row.
- i_Game_Active  in  1  level; 1 = ball in play.
- i_Reflect_X  in  1  one-cycle pulse from paddle collision logic; flips horizontal direction.
- o_HSync  out  1  i_HSync delayed 1 cycle.
- o_VSync  out  1  i_VSync delayed 1 cycle.
- o_Draw_Ball  out  1  current pixel lies in the ball tile.
- o_Ball_X  out  6  ball tile column.
- o_Ball_Y  out  6  ball tile row.
- o_Miss_L  out  1  one-cycle pulse: ball reached column 0.
- o_Miss_R  out  1  one-cycle pulse: ball reached column GAME_WIDTH-1.

## Operation
- States: IDLE, RUN.
- Reset (async, i_Rst_L=0):
  - state IDLE; Ball_X=GAME_WIDTH/2 (20); Ball_Y=GAME_HEIGHT/2 (15).
  - x_dir=right; y_dir=down; step counter 0.
  - all outputs 0, except o_Ball_X/o_Ball_Y, which show the centre.
- IDLE:
  - ball held at centre; step counter held at 0; i_Reflect_X ignored.
  - i_Game_Active=1 moves to RUN on the next edge.
- RUN:
  - step counter counts 0..BALL_SPEED-1 and wraps.
  - At terminal count, one step: X±1 per x_dir, Y±1 per y_dir.
- Y walls:
  - On a step with y_dir=down and Y==GAME_HEIGHT-1: y_dir becomes up and Y<=Y-1.
  - Same rule mirrored at Y==0 with y_dir=up.
  - Ball never leaves 0..GAME_HEIGHT-1.
- X edges:
  - A step landing on X==0 pulses o_Miss_L; landing on X==GAME_WIDTH-1 pulses o_Miss_R. The pulse is asserted in the cycle after the step.
  - Same edge: state returns to IDLE, ball recentres, counter clears, x_dir inverts (serve toward the scorer), y_dir keeps its value.
- i_Reflect_X:
  - In RUN, inverts x_dir on the next edge.
  - If it coincides with a step cycle, the step uses the inverted direction.
- i_Game_Active=0 in RUN: IDLE on the next edge with recentre; no miss pulse.
- Miss step and i_Game_Active falling in the same cycle: miss pulse still issued; IDLE entered once.
- Draw:
  - o_Draw_Ball <= (i_Col_Count[9:4]==Ball_X) && (i_Row_Count[9:4]==Ball_Y).
  - The comparison uses the Ball_X/Ball_Y values held before the edge.
  - Drawn in both IDLE and RUN.
- Widths: step counter is $clog2(BALL_SPEED) bits. Ball coordinates are 6 bits, unsigned, and never under- or overflow, because edges are caught before wrap.

## Timing
- o_HSync, o_VSync and o_Draw_Ball: exactly 1 cycle latency from inputs; all three stay mutually aligned.
- Position update: visible on o_Ball_X/o_Ball_Y 1 cycle after the terminal-count cycle.
- Step period in RUN: exactly BALL_SPEED cycles.
- First step occurs BALL_SPEED cycles after entering RUN.
- o_Miss_L/o_Miss_R: high for exactly 1 cycle, coincident with the recentred position.
- i_Rst_L asserted mid-step: all state clears immediately; no pulse is emitted.

## Structure
- Shared package pong_pkg holds:
  - TILE_SHIFT=4 and default GAME_WIDTH/GAME_HEIGHT;
  - the state enum (IDLE, RUN);
  - the direction encoding (0=right/down, 1=left/up).
- One sub-module: pong_step_timer. It is the parameterised BALL_SPEED counter with clear and enable, outputting a one-cycle step strobe.
- FSM, position/direction registers and draw/sync pipeline live in pong_ball_ctrl.

## Test plan
Use BALL_SPEED=4 throughout.
- Reset then release with i_Game_Active=0 for 100 cycles -> o_Ball_X=20, o_Ball_Y=15, o_Miss_L=o_Miss_R=0.
- i_Game_Active=1 from the centre -> steps every 4 cycles giving (21,16), (22,17), ...
- Bottom wall: ball at Y=29, y_dir down, step -> Y=28 and y_dir up.
- Right edge: run until X=39 -> o_Miss_R pulses 1 cycle; position (20,15); state IDLE; next serve moves to X=19.
- i_Reflect_X pulsed on a step cycle at X=25 moving right -> X=24. Also pulse i_Reflect_X in IDLE -> no effect.
- Draw alignment:
  - Counts Col=320..335, Row=240..255 with ball at (20,15) -> o_Draw_Ball high for those 16 pixels per row, 1 cycle late, aligned with o_HSync/o_VSync.
  - Assert i_Rst_L=0 mid-RUN -> all outputs are at reset values immediately.
